// File: rtl/uart_tx_if.sv
// Byte-side handshake and serial line of the UART transmitter.
// The system side uses the master modport; the transmitter uses the slave modport.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output PAR_TYP,
      input  TX_OUT,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  PAR_TYP,
      output TX_OUT,
      output Busy
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
// Each bit lasts PRESCALE clocks. Define UART_TX_PARITY_EN to build the parity bit logic.
//
// state  | meaning
// IDLE   | line high, Busy low, waiting for Data_Valid
// START  | driving the start bit (0)
// DATA   | driving data bit bit_cnt, LSB first
// PARITY | driving the parity bit (only when UART_TX_PARITY_EN is defined)
// STOP   | driving the stop bit (1); leaving it ends the frame
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   localparam int                EW        = $clog2(PRESCALE);
   localparam logic [EW-1:0]     EDGE_LAST = EW'(PRESCALE - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t                state;
   logic [EW-1:0]         edge_cnt;
   logic [2:0]            bit_cnt;
   logic [DATA_WIDTH-1:0] data_sr;
   logic                  tx_q;
   logic                  busy_q;
   logic                  edge_last;

`ifdef UART_TX_PARITY_EN
   logic                  par_en_q;
   logic                  par_bit_q;
`else
   logic                  unused_par;
   assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

   assign edge_last  = (edge_cnt == EDGE_LAST);
   assign bus.TX_OUT = tx_q;
   assign bus.Busy   = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         edge_cnt  <= '0;
         bit_cnt   <= '0;
         data_sr   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx_q     <= 1'b1;
               busy_q   <= 1'b0;
               edge_cnt <= '0;
               bit_cnt  <= '0;
               if (bus.Data_Valid) begin
                  // The shift register doubles as the frame's latched copy of P_DATA.
                  data_sr   <= bus.P_DATA;
`ifdef UART_TX_PARITY_EN
                  par_en_q  <= bus.PAR_EN;
                  par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= START;
               end
            end

            START: begin
               if (edge_last) begin
                  edge_cnt <= '0;
                  bit_cnt  <= '0;
                  tx_q     <= data_sr[0];
                  data_sr  <= data_sr >> 1;
                  state    <= DATA;
               end else begin
                  edge_cnt <= edge_cnt + 1'b1;
               end
            end

            DATA: begin
               if (edge_last) begin
                  edge_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     if (par_en_q) begin
                        tx_q  <= par_bit_q;
                        state <= PARITY;
                     end else begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                     end
`else
                     tx_q  <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx_q    <= data_sr[0];
                     data_sr <= data_sr >> 1;
                  end
               end else begin
                  edge_cnt <= edge_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (edge_last) begin
                  edge_cnt <= '0;
                  tx_q     <= 1'b1;
                  state    <= STOP;
               end else begin
                  edge_cnt <= edge_cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (edge_last) begin
                  edge_cnt <= '0;
                  tx_q     <= 1'b1;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end else begin
                  edge_cnt <= edge_cnt + 1'b1;
               end
            end

            default: begin
               edge_cnt <= '0;
               bit_cnt  <= '0;
               tx_q     <= 1'b1;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames against a bit-list model.
// Parity expectations follow whether UART_TX_PARITY_EN is defined for the build.
module tb_uart_tx;

   localparam int DW = 8;
   localparam int PS = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   uart_tx_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the frame as a list of line levels, one per bit period.
   function automatic void build_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                                       output bit bits[$]);
      int ones;
      bits.delete();
      ones = 0;
      bits.push_back(1'b0);
      for (int k = 0; k < DW; k++) begin
         bits.push_back(d[k]);
         if (d[k]) ones++;
      end
`ifdef UART_TX_PARITY_EN
      if (pen) bits.push_back(((ones % 2) == 1) ^ ptyp);
`else
      if (pen || ptyp) begin end
`endif
      bits.push_back(1'b1);
   endfunction

   // mode 0: noise on inputs; 1: ignored request at cycle 20; 2: hold Data_Valid with d2;
   // 3: reset at cycle 30
   task automatic frame(input logic [7:0] d, input bit pen, input bit ptyp,
                        input int mode, input logic [7:0] d2);
      bit sim_bits[$];
      int len;
      int busy_cnt;
      int exp_len;
      build_frame(d, pen, ptyp, sim_bits);
      len = sim_bits.size() * PS;
`ifdef UART_TX_PARITY_EN
      exp_len = (DW + 2 + (pen ? 1 : 0)) * PS;
`else
      exp_len = (DW + 2) * PS;
`endif
      busy_cnt = 0;
      bus.P_DATA     = d;
      bus.PAR_EN     = pen;
      bus.PAR_TYP    = ptyp;
      bus.Data_Valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         check($sformatf("tx[%0h] cyc%0d", d, i), {31'd0, bus.TX_OUT}, {31'd0, sim_bits[i / PS]});
         check($sformatf("busy[%0h] cyc%0d", d, i), {31'd0, bus.Busy}, 32'd1);
         if (bus.Busy === 1'b1) busy_cnt++;
         if (mode == 3 && i == 30) begin
            rst = 1'b1;
            bus.Data_Valid = 1'b0;
            @(negedge clk);
            check("rst_mid tx", {31'd0, bus.TX_OUT}, 32'd1);
            check("rst_mid busy", {31'd0, bus.Busy}, 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("post_rst tx", {31'd0, bus.TX_OUT}, 32'd1);
            check("post_rst busy", {31'd0, bus.Busy}, 32'd0);
            return;
         end
         if (mode == 2) begin
            bus.Data_Valid = 1'b1;
            bus.P_DATA     = d2;
         end else begin
            bus.P_DATA     = 8'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            bus.Data_Valid = (mode == 1 && i == 20) ? 1'b1 : 1'b0;
            if (mode == 1 && i == 20) bus.P_DATA = 8'h3C;
         end
      end
      check($sformatf("busy_len[%0h]", d), busy_cnt, exp_len);
      @(negedge clk);
      check($sformatf("idle_tx[%0h]", d), {31'd0, bus.TX_OUT}, 32'd1);
      check($sformatf("idle_busy[%0h]", d), {31'd0, bus.Busy}, 32'd0);
      if (mode != 2) begin
         bus.Data_Valid = 1'b0;
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("no_frame_tx[%0h]", d), {31'd0, bus.TX_OUT}, 32'd1);
            check($sformatf("no_frame_busy[%0h]", d), {31'd0, bus.Busy}, 32'd0);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.P_DATA     = '0;
      bus.Data_Valid = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset tx", {31'd0, bus.TX_OUT}, 32'd1);
         check("reset busy", {31'd0, bus.Busy}, 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset tx", {31'd0, bus.TX_OUT}, 32'd1);
         check("post_reset busy", {31'd0, bus.Busy}, 32'd0);
      end

      frame(8'hA5, 1'b0, 1'b0, 0, 8'h00);
      frame(8'hA5, 1'b1, 1'b0, 0, 8'h00);
      frame(8'hA5, 1'b1, 1'b1, 0, 8'h00);
      frame(8'h01, 1'b1, 1'b0, 0, 8'h00);
      frame(8'hA5, 1'b0, 1'b0, 1, 8'h00);
      frame(8'h55, 1'b0, 1'b0, 2, 8'hAA);
      frame(8'hAA, 1'b0, 1'b0, 0, 8'h00);
      frame(8'hA5, 1'b0, 1'b0, 3, 8'h00);
      frame(8'h0F, 1'b0, 1'b0, 0, 8'h00);
      frame(8'h5A, 1'b1, 1'b0, 2, 8'hC3);
      frame(8'hC3, 1'b1, 1'b0, 0, 8'h00);

      for (int n = 0; n < 8; n++) begin
         frame(8'($urandom), 1'($urandom), 1'($urandom), 0, 8'h00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
